// File: rtl/sgd_x_wb_burst_scheduler.sv
// sgd_x_wb_burst_scheduler
// Drains the per-engine x FIFOs once per epoch in fixed engine/line order and
// writes the lines to host memory as bursts of at most MAX_BURST_LINES lines.
// Build option: define SGD_X_WB_EPOCH_OFFSET_EN to place epoch k at
// addr_model + k*epoch_lines*64; when undefined every epoch overwrites addr_model.
module sgd_x_wb_burst_scheduler #(
  parameter int ENGINE_NUM      = 8,
  parameter int LINES_PER_ENG   = 4,
  parameter int FEAT_PER_ENG    = 64,
  parameter int MAX_BURST_LINES = 64,
  parameter int ADDR_WIDTH      = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     addr_model,
  input  logic [31:0]               dimension,
  input  logic [31:0]               num_epochs,
  input  logic [ENGINE_NUM-1:0]     fifo_empty,
  input  logic [ENGINE_NUM*512-1:0] fifo_rd_data,
  output logic [ENGINE_NUM-1:0]     fifo_rd_en,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [ADDR_WIDTH-1:0]     cmd_addr,
  output logic [31:0]               cmd_length,
  output logic [511:0]              data_out,
  output logic                      data_out_valid,
  input  logic                      data_out_almost_full,
  output logic                      epoch_done,
  output logic                      all_done,
  output logic                      busy,
  output logic                      err_dim_zero
);

  localparam int ENG_W     = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
  localparam int LINE_W    = (LINES_PER_ENG > 1) ? $clog2(LINES_PER_ENG) : 1;
  localparam int ROW_FEAT  = ENGINE_NUM * FEAT_PER_ENG;
  localparam int ROW_LINES = ENGINE_NUM * LINES_PER_ENG;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_CMD, S_DATA, S_DRAIN, S_DONE} state_t;

  state_t                  state_r, state_nxt;
  logic [31:0]             dim_r, nep_r, epoch_r;
  logic [ADDR_WIDTH-1:0]   base_r, waddr_r;
  logic [31:0]             remaining_r, burst_r, beats_r;
  logic [ENG_W-1:0]        eng_r;
  logic [LINE_W-1:0]       line_r;
  logic                    drain_cnt_r, err_r, epoch_done_r;

  logic [32:0]             rows_c;
  logic [31:0]             epoch_lines_c, burst_c, burst_bytes_c, rem_next_c;
  logic                    pop_c, last_pop_c;

  logic                    vld_p1;
  logic [ENG_W-1:0]        sel_p1;
  logic [511:0]            lane_w [ENGINE_NUM];

  // Epoch sizing, burst sizing and the pop qualifier derived from current state.
  always_comb begin
    rows_c        = ({1'b0, dim_r} + 33'(ROW_FEAT - 1)) / 33'(ROW_FEAT);
    epoch_lines_c = 32'(rows_c * 33'(ROW_LINES));
    burst_c       = (remaining_r > 32'(MAX_BURST_LINES)) ? 32'(MAX_BURST_LINES) : remaining_r;
    burst_bytes_c = burst_c << 6;
    rem_next_c    = remaining_r - burst_r;
    pop_c         = (state_r == S_DATA) && !fifo_empty[eng_r] && !data_out_almost_full &&
                    (beats_r != 32'd0);
    last_pop_c    = pop_c && (beats_r == 32'd1);
  end

  // Next-state logic and the command/pop outputs that follow the state.
  always_comb begin
    state_nxt  = state_r;
    fifo_rd_en = '0;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_length = '0;
    all_done   = 1'b0;
    busy       = (state_r != S_IDLE);
    case (state_r)
      S_IDLE: begin
        if (start && (dimension != 32'd0))
          state_nxt = (num_epochs == 32'd0) ? S_DONE : S_CALC;
      end
      S_CALC: state_nxt = S_CMD;
      S_CMD: begin
        cmd_valid  = 1'b1;
        cmd_addr   = waddr_r;
        cmd_length = burst_bytes_c;
        if (cmd_ready) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (pop_c) fifo_rd_en = ENGINE_NUM'(1) << eng_r;
        if (last_pop_c) state_nxt = (rem_next_c != 32'd0) ? S_CMD : S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt_r)
          state_nxt = ((epoch_r + 32'd1) == nep_r) ? S_DONE : S_CALC;
      end
      S_DONE: begin
        all_done = 1'b1;
        if (start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control registers: job config, epoch/burst counters and engine/line cursor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      dim_r        <= '0;
      nep_r        <= '0;
      epoch_r      <= '0;
      base_r       <= '0;
      waddr_r      <= '0;
      remaining_r  <= '0;
      burst_r      <= '0;
      beats_r      <= '0;
      eng_r        <= '0;
      line_r       <= '0;
      drain_cnt_r  <= 1'b0;
      err_r        <= 1'b0;
      epoch_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      epoch_done_r <= (state_r == S_DRAIN) && drain_cnt_r;
      drain_cnt_r  <= (state_r == S_DRAIN) ? ~drain_cnt_r : 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            dim_r   <= dimension;
            nep_r   <= num_epochs;
            base_r  <= addr_model;
            epoch_r <= '0;
            if (dimension == 32'd0) err_r <= 1'b1;
          end
        end
        S_CALC: begin
          remaining_r <= epoch_lines_c;
          eng_r       <= '0;
          line_r      <= '0;
`ifdef SGD_X_WB_EPOCH_OFFSET_EN
          // Later epochs continue from where the previous epoch's writes ended.
          if (epoch_r == 32'd0) waddr_r <= base_r;
`else
          waddr_r <= base_r;
`endif
        end
        S_CMD: begin
          if (cmd_ready) begin
            burst_r <= burst_c;
            beats_r <= burst_c;
            waddr_r <= waddr_r + ADDR_WIDTH'(burst_bytes_c);
          end
        end
        S_DATA: begin
          if (pop_c) begin
            beats_r <= beats_r - 32'd1;
            if (line_r == LINE_W'(LINES_PER_ENG - 1)) begin
              line_r <= '0;
              eng_r  <= (eng_r == ENG_W'(ENGINE_NUM - 1)) ? '0 : eng_r + ENG_W'(1);
            end else begin
              line_r <= line_r + LINE_W'(1);
            end
            if (last_pop_c) remaining_r <= rem_next_c;
          end
        end
        S_DRAIN: begin
          if (drain_cnt_r) epoch_r <= epoch_r + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign epoch_done   = epoch_done_r;
  assign err_dim_zero = err_r;

  for (genvar g = 0; g < ENGINE_NUM; g++) begin : g_lane
    assign lane_w[g] = fifo_rd_data[g*512 +: 512];
  end

  // ---- stage p1: FIFO dout becomes valid one cycle after the pop ----
  // Valid for the popped line.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= pop_c;
  end

  // Remember which engine was popped so the right lane is captured.
  always_ff @(posedge clk) begin
    sel_p1 <= eng_r;
  end

  // ---- stage p2: registered write data, two cycles after the pop ----
  // Capture the selected lane and present it with its strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= vld_p1;
      if (vld_p1) data_out <= lane_w[sel_p1];
    end
  end

endmodule

// File: tb/tb_sgd_x_wb_burst_scheduler.sv
// Self-checking bench for sgd_x_wb_burst_scheduler: randomized job sequences
// checked against a queue-based reference of the expected commands and data.
module tb_sgd_x_wb_burst_scheduler;
  localparam int EN  = 8;
  localparam int LPE = 4;
  localparam int FPE = 64;
  localparam int MBL = 64;
  localparam int AW  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [AW-1:0]     addr_model = '0;
  logic [31:0]       dimension = '0;
  logic [31:0]       num_epochs = '0;
  logic [EN-1:0]     fifo_empty = '0;
  logic [EN*512-1:0] fifo_rd_data = '0;
  logic [EN-1:0]     fifo_rd_en;
  logic              cmd_valid;
  logic              cmd_ready = 1'b0;
  logic [AW-1:0]     cmd_addr;
  logic [31:0]       cmd_length;
  logic [511:0]      data_out;
  logic              data_out_valid;
  logic              data_out_almost_full = 1'b0;
  logic              epoch_done, all_done, busy, err_dim_zero;

  int checks = 0;
  int errors = 0;

  sgd_x_wb_burst_scheduler #(
    .ENGINE_NUM(EN), .LINES_PER_ENG(LPE), .FEAT_PER_ENG(FPE),
    .MAX_BURST_LINES(MBL), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr_model(addr_model),
    .dimension(dimension), .num_epochs(num_epochs), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_length(cmd_length),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_almost_full(data_out_almost_full), .epoch_done(epoch_done),
    .all_done(all_done), .busy(busy), .err_dim_zero(err_dim_zero)
  );

  // Every line an engine ever supplies is unique: engine id and per-engine pop index.
  function automatic logic [511:0] word_of(input int e, input int k);
    logic [31:0] v;
    v = 32'(e * 65536 + k) ^ 32'h5A00_0000;
    return {16{v}};
  endfunction

  // FIFO model: read latency 1, never runs dry unless the bench says empty.
  int f_cnt [EN] = '{default: 0};
  always @(posedge clk) begin
    for (int e = 0; e < EN; e++) begin
      if (fifo_rd_en[e]) begin
        fifo_rd_data[e*512 +: 512] <= word_of(e, f_cnt[e]);
        f_cnt[e] <= f_cnt[e] + 1;
      end
    end
  end

  // Stimulus modes
  int            rdy_mode = 0;
  bit            emp_rand = 0, af_rand = 0, force_af = 0, stall_arm = 0;
  logic [EN-1:0] force_emp = '0;
  int            stall_thr = 0;
  logic [EN-1:0] emp_m;

  initial begin
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       cmd_ready = 1'b1;
        1:       cmd_ready = ($urandom_range(0, 3) != 0);
        default: cmd_ready = 1'b0;
      endcase
      emp_m = force_emp;
      if (emp_rand)
        for (int e = 0; e < EN; e++) if ($urandom_range(0, 7) == 0) emp_m[e] = 1'b1;
      if (stall_arm && f_cnt[3] >= stall_thr) emp_m[3] = 1'b1;
      fifo_empty = emp_m;
      data_out_almost_full = force_af | (af_rand && ($urandom_range(0, 5) == 0));
    end
  end

  // Monitor: captures commands/data and counts protocol violations.
  logic [AW-1:0]  cap_addr [$];
  int             cap_len  [$];
  logic [511:0]   cap_data [$];
  int pop_cnt, ep_cnt, credit, viol_pop, viol_early, viol_beats, viol_lat, viol_stab;
  logic [1:0]     hist = '0;
  logic           prev_cv = 1'b0;
  logic [AW-1:0]  prev_addr;
  logic [31:0]    prev_len;

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        hist = '0; prev_cv = 1'b0; credit = 0;
        continue;
      end
      if (prev_cv && cmd_valid && (cmd_addr !== prev_addr || cmd_length !== prev_len)) viol_stab++;
      prev_cv = cmd_valid && !cmd_ready;
      prev_addr = cmd_addr;
      prev_len = cmd_length;
      if (cmd_valid && cmd_ready) begin
        if (credit != 0) viol_beats++;
        credit = int'(cmd_length) / 64;
        cap_addr.push_back(cmd_addr);
        cap_len.push_back(int'(cmd_length));
      end
      if (fifo_rd_en != '0) begin
        pop_cnt++;
        if (!$onehot(fifo_rd_en) || ((fifo_rd_en & fifo_empty) != '0) || data_out_almost_full)
          viol_pop++;
        if (credit == 0) viol_early++;
        else credit--;
      end
      if (data_out_valid) cap_data.push_back(data_out);
      if (data_out_valid !== hist[1]) viol_lat++;
      hist = {hist[0], (fifo_rd_en != '0)};
      if (epoch_done) ep_cnt++;
    end
  end

  task automatic clear_mon();
    cap_addr.delete(); cap_len.delete(); cap_data.delete();
    pop_cnt = 0; ep_cnt = 0; credit = 0;
    viol_pop = 0; viol_early = 0; viol_beats = 0; viol_lat = 0; viol_stab = 0;
  endtask

  // Reference model: expected command list and line stream for one job.
  logic [AW-1:0] exp_addr [$];
  int            exp_len  [$];
  logic [511:0]  exp_data [$];
  int            m_cnt [EN] = '{default: 0};

  task automatic build_expect(input longint dim, input int ne, input logic [AW-1:0] base);
    longint rows, lines, rem, b;
    logic [AW-1:0] a;
    exp_addr.delete(); exp_len.delete(); exp_data.delete();
    rows  = (dim + EN * FPE - 1) / (EN * FPE);
    lines = rows * EN * LPE;
    for (int k = 0; k < ne; k++) begin
      a = base;
`ifdef SGD_X_WB_EPOCH_OFFSET_EN
      a = base + AW'(k * lines * 64);
`endif
      rem = lines;
      while (rem > 0) begin
        b = (rem > MBL) ? MBL : rem;
        exp_addr.push_back(a);
        exp_len.push_back(int'(b * 64));
        a   = a + AW'(b * 64);
        rem = rem - b;
      end
      for (longint i = 0; i < lines; i++) begin
        int e;
        e = int'((i / LPE) % EN);
        exp_data.push_back(word_of(e, m_cnt[e]));
        m_cnt[e]++;
      end
    end
  endtask

  task automatic pulse_start(input logic [31:0] dim, input logic [31:0] ne, input logic [AW-1:0] a);
    @(negedge clk);
    dimension = dim; num_epochs = ne; addr_model = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    for (int i = 0; i < 20000; i++) begin
      if (all_done) break;
      @(negedge clk);
    end
    timed_out = !all_done;
    repeat (2) @(negedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || all_done !== 1'b0 || epoch_done !== 1'b0 || err_dim_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b all_done=%b epoch_done=%b err=%b required 0000",
               busy, all_done, epoch_done, err_dim_zero);
    end
    checks++;
    if (cmd_valid !== 1'b0 || cmd_addr !== '0 || cmd_length !== '0) begin
      errors++;
      $display("FAIL reset_cmd: valid=%b addr=%h len=%0d required 0", cmd_valid, cmd_addr, cmd_length);
    end
    checks++;
    if (fifo_rd_en !== '0 || data_out_valid !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL reset_data: rd_en=%b dvalid=%b data=%h required 0",
               fifo_rd_en, data_out_valid, data_out[63:0]);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b required 0", busy);
    end
  endtask

  task automatic test_jobs();
    int t_dim [8] = '{512, 1, 1024, 513, 2560, 512, 700, 512};
    int t_ne  [8] = '{1, 1, 1, 1, 1, 3, 2, 0};
    int t_rdy [8] = '{0, 1, 0, 1, 1, 0, 1, 0};
    bit t_emp [8] = '{0, 1, 0, 1, 1, 0, 1, 0};
    bit t_af  [8] = '{0, 0, 1, 1, 1, 0, 1, 0};
    logic [AW-1:0] a;
    bit to;
    for (int j = 0; j < 8; j++) begin
      a = {$urandom, $urandom};
      a[5:0] = '0;
      if (j == 0) a = 64'h0000_0000_1000_0000;
      rdy_mode = t_rdy[j]; emp_rand = t_emp[j]; af_rand = t_af[j];
      clear_mon();
      build_expect(t_dim[j], t_ne[j], a);
      pulse_start(t_dim[j], t_ne[j], a);
      wait_done(to);
      rdy_mode = 0; emp_rand = 0; af_rand = 0;
      checks++;
      if (to) begin
        errors++;
        $display("FAIL job%0d_done: all_done=%b required 1", j, all_done);
      end
      checks++;
      if (cap_addr.size() != exp_addr.size()) begin
        errors++;
        $display("FAIL job%0d_cmd_count: got %0d required %0d", j, cap_addr.size(), exp_addr.size());
      end else begin
        for (int i = 0; i < exp_addr.size(); i++) begin
          checks++;
          if (cap_addr[i] !== exp_addr[i] || cap_len[i] !== exp_len[i]) begin
            errors++;
            $display("FAIL job%0d_cmd%0d: addr=%h len=%0d required addr=%h len=%0d",
                     j, i, cap_addr[i], cap_len[i], exp_addr[i], exp_len[i]);
          end
        end
      end
      checks++;
      if (cap_data.size() != exp_data.size()) begin
        errors++;
        $display("FAIL job%0d_beat_count: got %0d required %0d", j, cap_data.size(), exp_data.size());
      end else begin
        for (int i = 0; i < exp_data.size(); i++) begin
          checks++;
          if (cap_data[i] !== exp_data[i]) begin
            errors++;
            $display("FAIL job%0d_beat%0d: data=%h required %h", j, i, cap_data[i][63:0], exp_data[i][63:0]);
            break;
          end
        end
      end
      checks++;
      if (ep_cnt != t_ne[j]) begin
        errors++;
        $display("FAIL job%0d_epoch_done: pulses=%0d required %0d", j, ep_cnt, t_ne[j]);
      end
      checks++;
      if (viol_pop != 0 || viol_early != 0 || viol_beats != 0 || credit != 0) begin
        errors++;
        $display("FAIL job%0d_pop_rules: bad_pop=%0d early=%0d beat_mis=%0d credit=%0d required 0",
                 j, viol_pop, viol_early, viol_beats, credit);
      end
      checks++;
      if (viol_lat != 0 || viol_stab != 0) begin
        errors++;
        $display("FAIL job%0d_timing: latency_err=%0d cmd_unstable=%0d required 0", j, viol_lat, viol_stab);
      end
      checks++;
      if (busy !== 1'b1 || all_done !== 1'b1) begin
        errors++;
        $display("FAIL job%0d_done_state: busy=%b all_done=%b required 11", j, busy, all_done);
      end
      go_idle();
      checks++;
      if (busy !== 1'b0 || all_done !== 1'b0) begin
        errors++;
        $display("FAIL job%0d_back_idle: busy=%b all_done=%b required 00", j, busy, all_done);
      end
    end
  endtask

  task automatic test_cmd_hold();
    logic [AW-1:0] a0;
    logic [31:0] l0;
    int p0, bad;
    bit to;
    clear_mon();
    build_expect(513, 1, 64'h0000_0002_0000_0040);
    rdy_mode = 2;
    pulse_start(513, 1, 64'h0000_0002_0000_0040);
    for (int i = 0; i < 50 && !cmd_valid; i++) @(negedge clk);
    a0 = cmd_addr; l0 = cmd_length; p0 = pop_cnt; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!cmd_valid || cmd_addr !== a0 || cmd_length !== l0) bad++;
    end
    checks++;
    if (bad != 0 || a0 !== exp_addr[0] || l0 !== 32'(exp_len[0])) begin
      errors++;
      $display("FAIL hold_cmd: unstable=%0d addr=%h len=%0d required 0 %h %0d",
               bad, a0, l0, exp_addr[0], exp_len[0]);
    end
    checks++;
    if (pop_cnt != p0) begin
      errors++;
      $display("FAIL hold_no_pop: pops=%0d required %0d", pop_cnt, p0);
    end
    rdy_mode = 0;
    wait_done(to);
    checks++;
    if (to || cap_data.size() != exp_data.size() || cap_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL hold_complete: timeout=%b beats=%0d cmds=%0d required 0 %0d %0d",
               to, cap_data.size(), cap_addr.size(), exp_data.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        checks++;
        if (cap_data[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL hold_beat%0d: data=%h required %h", i, cap_data[i][63:0], exp_data[i][63:0]);
          break;
        end
      end
    end
    go_idle();
  endtask

  task automatic test_engine_stall();
    int p0;
    bit to;
    clear_mon();
    build_expect(512, 1, 64'h0000_0000_0008_0000);
    stall_thr = f_cnt[3] + 1;
    stall_arm = 1'b1;
    pulse_start(512, 1, 64'h0000_0000_0008_0000);
    for (int i = 0; i < 200 && !fifo_empty[3]; i++) begin
      @(negedge clk); #1;
    end
    @(negedge clk);
    p0 = pop_cnt;
    repeat (20) @(negedge clk);
    checks++;
    if (pop_cnt != p0 || p0 != 13) begin
      errors++;
      $display("FAIL stall_empty: pops_before=%0d pops_after=%0d required 13 13", p0, pop_cnt);
    end
    force_af = 1'b1;
    repeat (2) @(negedge clk);
    stall_arm = 1'b0;
    repeat (2) @(negedge clk);
    p0 = pop_cnt;
    repeat (5) @(negedge clk);
    checks++;
    if (pop_cnt != p0) begin
      errors++;
      $display("FAIL stall_almost_full: pops=%0d required %0d", pop_cnt, p0);
    end
    force_af = 1'b0;
    af_rand = 1'b1;
    repeat (20) @(negedge clk);
    af_rand = 1'b0;
    wait_done(to);
    checks++;
    if (to || cap_data.size() != exp_data.size()) begin
      errors++;
      $display("FAIL stall_complete: timeout=%b beats=%0d required 0 %0d", to, cap_data.size(), exp_data.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        checks++;
        if (cap_data[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL stall_beat%0d: data=%h required %h", i, cap_data[i][63:0], exp_data[i][63:0]);
          break;
        end
      end
    end
    checks++;
    if (viol_pop != 0 || viol_lat != 0 || viol_early != 0) begin
      errors++;
      $display("FAIL stall_rules: bad_pop=%0d latency_err=%0d early=%0d required 0", viol_pop, viol_lat, viol_early);
    end
    go_idle();
  endtask

  task automatic test_dim_zero();
    pulse_start(0, 1, 64'h0000_0000_0000_1000);
    repeat (2) @(negedge clk);
    checks++;
    if (err_dim_zero !== 1'b1 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL dim_zero: err=%b busy=%b cmd_valid=%b required 1 0 0", err_dim_zero, busy, cmd_valid);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    pulse_start(2560, 1, 64'h0000_0000_0040_0000);
    for (int i = 0; i < 300 && pop_cnt < 20; i++) @(negedge clk);
    checks++;
    if (pop_cnt < 20) begin
      errors++;
      $display("FAIL rst_mid_reach_data: pops=%0d required >=20", pop_cnt);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || all_done !== 1'b0 || epoch_done !== 1'b0 || err_dim_zero !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_status: busy=%b all_done=%b epoch_done=%b err=%b required 0000",
               busy, all_done, epoch_done, err_dim_zero);
    end
    checks++;
    if (fifo_rd_en !== '0 || cmd_valid !== 1'b0 || data_out_valid !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: rd_en=%b cmd_valid=%b dvalid=%b data=%h required 0",
               fifo_rd_en, cmd_valid, data_out_valid, data_out[63:0]);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fifo_rd_en !== '0 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_stays_idle: busy=%b rd_en=%b cmd_valid=%b required 0", busy, fifo_rd_en, cmd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_jobs();
    test_cmd_hold();
    test_engine_stall();
    test_dim_zero();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
